// File: rtl/fpadd_pkg.sv
// fpadd_pkg: shared constants and width helpers for the
// parametrised pipelined floating-point adder.
package fpadd_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Full word width: sign, exponent, stored fraction.
    function automatic int fp_w(input int ew, input int fw);
        return 1 + ew + fw;
    endfunction

    // Aligned magnitude field: hidden, fraction, guard, round, sticky.
    function automatic int fp_aw(input int fw);
        return fw + 4;
    endfunction

    // Leading-zero count width for a field of the given width.
    function automatic int fp_cw(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// fp_lzc: combinational leading-zero counter.
// An all-zero input reports WIDTH.
module fp_lzc #(
    parameter int WIDTH = 56
) (
    input  logic [WIDTH-1:0]         i_d,
    output logic [$clog2(WIDTH):0]   o_cnt
);
    localparam int CW = $clog2(WIDTH) + 1;

    // Highest set bit wins because the scan runs upward.
    always_comb begin
        o_cnt = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (i_d[i]) o_cnt = CW'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/fpadd_p.sv
// fpadd_p: 3-stage back-pressured floating-point add/subtract,
// round to nearest-even, saturate on overflow, flush on underflow.
module fpadd_p
    import fpadd_pkg::*;
#(
    parameter int EW = 11,
    parameter int FW = 52
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pushin,
    input  logic                   op,
    input  logic [fp_w(EW,FW)-1:0] a,
    input  logic [fp_w(EW,FW)-1:0] b,
    output logic                   stopout,
    output logic                   pushout,
    input  logic                   stopin,
    output logic [fp_w(EW,FW)-1:0] r,
    output logic                   ovf,
    output logic                   unf
);
    localparam int W    = fp_w(EW, FW);
    localparam int AW   = fp_aw(FW);
    localparam int CW   = fp_cw(AW);
    localparam int XW   = EW + CW + 1;
    localparam int EMAX = (1 << EW) - 1;

    typedef struct packed {
        logic          sgn;
        logic          sub;
        logic [EW-1:0] exp;
        logic [AW-1:0] ma;
        logic [AW-1:0] mb;
    } s1_t;

    typedef struct packed {
        logic          sgn;
        logic          zero;
        logic [XW-1:0] exp;
        logic [AW-1:0] m;
        logic [CW-1:0] lz;
    } s2_t;

    logic            w_stall;
    logic            r_v1, r_v2, r_po;
    s1_t             r_s1, w_s1;
    s2_t             r_s2, w_s2;
    logic [W-1:0]    r_r, w_r;
    logic            r_ovf, r_unf, w_ovf, w_unf;

    logic [EW-1:0]   w_ea, w_eb, w_el, w_es, w_d;
    logic [FW-1:0]   w_fa, w_fb;
    logic [FW:0]     w_ma, w_mb, w_ml, w_ms;
    logic            w_sb, w_sl, w_ss, w_age;
    logic [2*AW-1:0] w_ext;
    logic [AW-1:0]   w_al;

    logic [AW:0]     w_sum;
    logic [AW-1:0]   w_m2;
    logic [CW-1:0]   w_lz;

    logic [AW-1:0]   w_n;
    logic            w_inc;
    logic [FW+1:0]   w_rm;
    logic signed [XW-1:0] w_e3;
    logic [FW-1:0]   w_f3;

    assign w_stall = r_po & stopin;
    assign stopout = w_stall;
    assign pushout = r_po;
    assign r       = r_r;
    assign ovf     = r_ovf;
    assign unf     = r_unf;

    assign w_ea = a[W-2:FW];
    assign w_eb = b[W-2:FW];
    assign w_fa = a[FW-1:0];
    assign w_fb = b[FW-1:0];
    assign w_sb = b[W-1] ^ (op == OP_SUB);

    // Stage 1: order by magnitude and align the smaller operand.
    always_comb begin
        w_age = {w_ea, w_fa} >= {w_eb, w_fb};
        w_ma  = (w_ea != '0) ? {1'b1, w_fa} : '0;
        w_mb  = (w_eb != '0) ? {1'b1, w_fb} : '0;
        if (w_age) begin
            w_el = w_ea; w_es = w_eb;
            w_ml = w_ma; w_ms = w_mb;
            w_sl = a[W-1]; w_ss = w_sb;
        end else begin
            w_el = w_eb; w_es = w_ea;
            w_ml = w_mb; w_ms = w_ma;
            w_sl = w_sb; w_ss = a[W-1];
        end
        w_d   = w_el - w_es;
        w_ext = {w_ms, 3'b000, {AW{1'b0}}} >> w_d;
        if (32'(w_d) >= AW)
            w_al = {{(AW-1){1'b0}}, |w_ms};
        else
            w_al = w_ext[2*AW-1:AW]
                 | {{(AW-1){1'b0}}, |w_ext[AW-1:0]};
        w_s1.sgn = w_sl;
        w_s1.sub = w_sl ^ w_ss;
        w_s1.exp = w_el;
        w_s1.ma  = {w_ml, 3'b000};
        w_s1.mb  = w_al;
    end

    // Stage 2: magnitude add/sub, fold carry-out back into the field.
    always_comb begin
        if (r_s1.sub)
            w_sum = {1'b0, r_s1.ma} - {1'b0, r_s1.mb};
        else
            w_sum = {1'b0, r_s1.ma} + {1'b0, r_s1.mb};
        if (w_sum[AW])
            w_m2 = {w_sum[AW:2], |w_sum[1:0]};
        else
            w_m2 = w_sum[AW-1:0];
        w_s2.sgn  = r_s1.sgn;
        w_s2.zero = (w_m2 == '0);
        w_s2.exp  = XW'(r_s1.exp) + XW'(w_sum[AW]);
        w_s2.m    = w_m2;
        w_s2.lz   = w_lz;
    end

    fp_lzc #(.WIDTH(AW)) u_lzc (
        .i_d   (w_m2),
        .o_cnt (w_lz)
    );

    // Stage 3: normalise, round to nearest-even, range-check exponent.
    always_comb begin
        w_n   = r_s2.m << r_s2.lz;
        w_inc = w_n[2] & (w_n[1] | w_n[0] | w_n[3]);
        w_rm  = {1'b0, w_n[AW-1:3]} + {{(FW+1){1'b0}}, w_inc};
        w_e3  = $signed(r_s2.exp) - $signed(XW'(r_s2.lz))
              + $signed(XW'(w_rm[FW+1]));
        w_f3  = w_rm[FW+1] ? w_rm[FW:1] : w_rm[FW-1:0];
        w_r   = '0;
        w_ovf = 1'b0;
        w_unf = 1'b0;
        if (r_s2.zero) begin
            w_r = '0;
        end else if (w_e3 > $signed(XW'(EMAX))) begin
            w_r   = {r_s2.sgn, {(W-1){1'b1}}};
            w_ovf = 1'b1;
        end else if (w_e3 < $signed(XW'(1))) begin
            w_unf = 1'b1;
        end else begin
            w_r = {r_s2.sgn, w_e3[EW-1:0], w_f3};
        end
    end

    // All stages advance together unless the consumer blocks the output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v1  <= 1'b0;
            r_v2  <= 1'b0;
            r_po  <= 1'b0;
            r_s1  <= '0;
            r_s2  <= '0;
            r_r   <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else if (!w_stall) begin
            r_v1 <= pushin;
            r_v2 <= r_v1;
            r_po <= r_v2;
            if (pushin) r_s1 <= w_s1;
            if (r_v1)   r_s2 <= w_s2;
            if (r_v2) begin
                r_r   <= w_r;
                r_ovf <= w_ovf;
                r_unf <= w_unf;
            end
        end
    end

endmodule
